raw_waw_scoreboard: RTL and testbench
=====================================

# raw_waw_scoreboard

Issue-side hazard scoreboard for one fixed-latency pipelined execution unit (FP mul/add/fused, integer mul) in the execute stage. It mirrors the unit's internal delay line with a LATENCY-deep shift register of {valid, rd, fp} entries. Using that shadow, it stalls decode on RAW and WAW hazards against in-flight destinations. It also turns flush requests into the per-stage clear vector that the unit's delay line consumes.

## Interface
Parameters:
- LATENCY, 3, pipeline depth of the tracked unit; must equal the delay-line depth; minimum 2.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- advance  in  1  unit pipeline enable; the same signal drives the delay line's wen.
- issue_valid  in  1  decode holds an instruction requesting issue.
- issue_to_unit  in  1  instruction executes in the tracked unit.
- issue_reg_write  in  1  instruction writes a destination register.
- issue_rd_fp  in  1  destination is in the FP register file.
- issue_rd  in  ADDR_W  destination address.
- issue_rs_used  in  3  source-used flags for rs1, rs2, rs3.
- issue_rs_fp  in  3  per-source FP-file select.
- issue_rs1, issue_rs2, issue_rs3  in  ADDR_W each  source addresses.
- flush_mask  in  LATENCY  stages to squash; bit 0 is the youngest stage.
- stall  out  1  hold decode this cycle.
- accept  out  1  issue_valid & ~stall & advance.
- unit_clr  out  LATENCY  per-stage clear to the unit delay line.
- busy_count  out  $clog2(LATENCY+1)  number of valid in-flight entries.

## Operation
- Entry k holds the operation issued k+1 advancing cycles earlier. Entry LATENCY-1 writes back in the current cycle.
- An entry is recorded into slot 0 on accept & issue_to_unit & issue_reg_write. Exception: an integer destination rd==0 is never recorded. FP f0 is recorded.
- Match rule: an entry is valid, and its rd and fp flag equal the compared address and file.
- RAW hazard: any used source matches any entry. With the forwarding macro defined, entry LATENCY-1 is excluded.
- WAW hazard: issue_reg_write and issue_rd/issue_rd_fp match any entry in slots 0..LATENCY-2. This holds for both unit and non-unit instructions. A match in slot LATENCY-1 retires this cycle and is not a hazard.
- stall = issue_valid & (RAW | WAW | ~advance). stall is combinational, in the same cycle as the inputs.
- Shift behaviour:
  - When advance=1, every entry moves up one slot, entry LATENCY-1 drops out, and slot 0 loads the new entry (or an invalid entry).
  - When advance=0, all entries hold.
- Flush:
  - flush_mask[k]=1 invalidates the entry that would occupy slot k after this edge. This applies with or without advance.
  - unit_clr = flush_mask, combinational, so the delay line and the scoreboard squash on the same edge.
  - A flush of slot 0 coincident with accept discards the new entry; the stall/accept outputs for that cycle are unchanged.
- busy_count is the registered population count of valid entries after the update.

## Timing
- Reset: all entries invalid, busy_count=0. On the reset cycle stall=issue_valid&~advance, and unit_clr follows flush_mask.
- Reset mid-operation: all in-flight entries are lost on the reset edge. Reset has priority over flush, shift and load.
- Issue-to-clear latency: a unit op accepted at edge T occupies slot 0 after T and slot LATENCY-1 after T+LATENCY-1. It no longer blocks RAW after T+LATENCY-1 with forwarding, or after T+LATENCY without it.
- Back-to-back unit issues to distinct rds are accepted every cycle; the shadow is full at LATENCY entries. There is no structural stall: the unit is fully pipelined.
- Same-rd back-to-back unit issue: the second is stalled on WAW until the first reaches slot LATENCY-1.

## Configuration
- SCOREBOARD_FWD_EN defined: the writeback-stage entry (slot LATENCY-1) is excluded from RAW comparison, because its result is forwarded.
- SCOREBOARD_FWD_EN undefined: all LATENCY slots participate in RAW. Dependent ops wait one extra cycle.

## Test plan
- Reset with issue_valid=1, advance=1, no entries -> stall=0, accept=1, busy_count=0, unit_clr=0.
- LATENCY=3. Issue unit op rd=f5 at T, then a dependent rs1=f5 (FP) every cycle -> stall for 2 cycles with FWD_EN, 3 without. busy_count is 1 while the entry is in flight.
- Issue unit ops rd=x0 and rd=x7 (int) -> x0 is never recorded (a later rs1=x0 never stalls); x7 is tracked. A source x7 with issue_rs_fp=1 (f7) does not stall.
- Unit op rd=x9, then an ALU op writing x9 -> WAW stall while the entry is in slots 0..1, released when it reaches slot 2.
- Entries in slots 0 and 1, flush_mask=3'b011 -> unit_clr=3'b011 the same cycle, busy_count=0 after the edge, and the dependent op is accepted next cycle.
- advance=0 for 4 cycles with an entry in slot 1 -> the entry holds, stall=1, accept=0. Then reset=1 -> busy_count=0 next cycle.

Source files
------------

// File: rtl/raw_waw_scoreboard_if.sv
// Issue/flush/status bundle between decode and the RAW/WAW hazard scoreboard.
// master = decode side, slave = scoreboard.
interface raw_waw_scoreboard_if #(
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 5
);
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic                advance;
  logic                issue_valid;
  logic                issue_to_unit;
  logic                issue_reg_write;
  logic                issue_rd_fp;
  logic [ADDR_W-1:0]   issue_rd;
  logic [2:0]          issue_rs_used;
  logic [2:0]          issue_rs_fp;
  logic [ADDR_W-1:0]   issue_rs1;
  logic [ADDR_W-1:0]   issue_rs2;
  logic [ADDR_W-1:0]   issue_rs3;
  logic [LATENCY-1:0]  flush_mask;
  logic                stall;
  logic                accept;
  logic [LATENCY-1:0]  unit_clr;
  logic [CNT_W-1:0]    busy_count;

  modport master (
    output advance, issue_valid, issue_to_unit, issue_reg_write, issue_rd_fp,
           issue_rd, issue_rs_used, issue_rs_fp, issue_rs1, issue_rs2, issue_rs3,
           flush_mask,
    input  stall, accept, unit_clr, busy_count
  );

  modport slave (
    input  advance, issue_valid, issue_to_unit, issue_reg_write, issue_rd_fp,
           issue_rd, issue_rs_used, issue_rs_fp, issue_rs1, issue_rs2, issue_rs3,
           flush_mask,
    output stall, accept, unit_clr, busy_count
  );
endinterface

// File: rtl/raw_waw_scoreboard.sv
// RAW/WAW issue scoreboard shadowing a LATENCY-deep fixed-latency unit.
// Optional macro SCOREBOARD_FWD_EN: writeback slot excluded from RAW (result forwarded).
module raw_waw_scoreboard #(
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 5
) (
  input logic               clk,
  input logic               reset,
  raw_waw_scoreboard_if.slave sb
);
  localparam int CNT_W = $clog2(LATENCY + 1);
`ifdef SCOREBOARD_FWD_EN
  localparam int RAW_SLOTS = LATENCY - 1;
`else
  localparam int RAW_SLOTS = LATENCY;
`endif

  logic [LATENCY-1:0] ent_valid;
  logic [LATENCY-1:0] ent_fp;
  logic [ADDR_W-1:0]  ent_rd [LATENCY];
  logic [CNT_W-1:0]   busy_q;

  logic [LATENCY-1:0] nxt_valid;
  logic [LATENCY-1:0] nxt_fp;
  logic [ADDR_W-1:0]  nxt_rd [LATENCY];
  logic [CNT_W-1:0]   nxt_cnt;

  logic [ADDR_W-1:0]  src_addr [3];
  logic               raw_hit;
  logic               waw_hit;
  logic               record;

  assign src_addr[0] = sb.issue_rs1;
  assign src_addr[1] = sb.issue_rs2;
  assign src_addr[2] = sb.issue_rs3;

  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      for (int s = 0; s < 3; s++) begin
        if (k < RAW_SLOTS && sb.issue_rs_used[s] && ent_valid[k] &&
            ent_rd[k] == src_addr[s] && ent_fp[k] == sb.issue_rs_fp[s])
          raw_hit = 1'b1;
      end
      // The writeback slot retires this cycle, so it cannot cause WAW.
      if (k < LATENCY - 1 && sb.issue_reg_write && ent_valid[k] &&
          ent_rd[k] == sb.issue_rd && ent_fp[k] == sb.issue_rd_fp)
        waw_hit = 1'b1;
    end
  end

  // Shadow contents are discarded on the reset edge, so hazards are masked in that cycle.
  assign sb.stall    = sb.issue_valid & (((raw_hit | waw_hit) & ~reset) | ~sb.advance);
  assign sb.accept   = sb.issue_valid & ~sb.stall & sb.advance;
  assign sb.unit_clr = sb.flush_mask;
  assign record      = sb.accept & sb.issue_to_unit & sb.issue_reg_write &
                       (sb.issue_rd_fp | (sb.issue_rd != '0));

  always_comb begin
    nxt_valid = ent_valid;
    nxt_fp    = ent_fp;
    for (int k = 0; k < LATENCY; k++) nxt_rd[k] = ent_rd[k];
    if (sb.advance) begin
      nxt_valid = {ent_valid[LATENCY-2:0], record};
      nxt_fp    = {ent_fp[LATENCY-2:0], sb.issue_rd_fp};
      nxt_rd[0] = sb.issue_rd;
      for (int k = 1; k < LATENCY; k++) nxt_rd[k] = ent_rd[k-1];
    end
    // Mask indexes post-edge slots, matching the unit's own delay-line clear.
    nxt_valid = nxt_valid & ~sb.flush_mask;
    nxt_cnt   = '0;
    for (int k = 0; k < LATENCY; k++) nxt_cnt = nxt_cnt + CNT_W'(nxt_valid[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      ent_fp    <= '0;
      busy_q    <= '0;
      for (int k = 0; k < LATENCY; k++) ent_rd[k] <= '0;
    end else begin
      ent_valid <= nxt_valid;
      ent_fp    <= nxt_fp;
      busy_q    <= nxt_cnt;
      for (int k = 0; k < LATENCY; k++) ent_rd[k] <= nxt_rd[k];
    end
  end

  assign sb.busy_count = busy_q;
endmodule

// File: tb/tb_raw_waw_scoreboard.sv
// Directed bench for raw_waw_scoreboard: list-of-in-flight-ops model plus literal checks.
// Honors SCOREBOARD_FWD_EN the same way as the design.
module tb_raw_waw_scoreboard;
  localparam int LAT = 3;
  localparam int AW  = 5;
`ifdef SCOREBOARD_FWD_EN
  localparam int RAW_LIM    = LAT - 1;
  localparam int RAW_STALLS = 2;
`else
  localparam int RAW_LIM    = LAT;
  localparam int RAW_STALLS = 3;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  raw_waw_scoreboard_if #(.LATENCY(LAT), .ADDR_W(AW)) sb_if ();
  raw_waw_scoreboard #(.LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each in-flight op knows how many advancing edges ago it issued (age = slot).
  typedef struct { logic [AW-1:0] rd; logic fp; int age; } op_t;
  op_t infl[$];
  bit  model_ok = 1'b0;

  function automatic bit m_match(logic [AW-1:0] a, logic f, int lim);
    foreach (infl[i])
      if (infl[i].age < lim && infl[i].rd == a && infl[i].fp == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    bit raw, waw;
    if (!sb_if.issue_valid) return 1'b0;
    if (!sb_if.advance) return 1'b1;
    if (reset) return 1'b0;
    raw = (sb_if.issue_rs_used[0] && m_match(sb_if.issue_rs1, sb_if.issue_rs_fp[0], RAW_LIM)) ||
          (sb_if.issue_rs_used[1] && m_match(sb_if.issue_rs2, sb_if.issue_rs_fp[1], RAW_LIM)) ||
          (sb_if.issue_rs_used[2] && m_match(sb_if.issue_rs3, sb_if.issue_rs_fp[2], RAW_LIM));
    waw = sb_if.issue_reg_write && m_match(sb_if.issue_rd, sb_if.issue_rd_fp, LAT - 1);
    return raw || waw;
  endfunction

  function automatic bit exp_accept();
    return sb_if.issue_valid && sb_if.advance && !exp_stall();
  endfunction

  always @(posedge clk) begin : model
    bit  acc;
    op_t nw;
    op_t nxt[$];
    if (reset) begin
      infl.delete();
      model_ok = 1'b1;
    end else begin
      acc = exp_accept();
      nxt.delete();
      foreach (infl[i]) begin
        nw = infl[i];
        if (sb_if.advance) nw.age = nw.age + 1;
        if (nw.age < LAT && !sb_if.flush_mask[nw.age]) nxt.push_back(nw);
      end
      if (acc && sb_if.issue_to_unit && sb_if.issue_reg_write &&
          (sb_if.issue_rd_fp || sb_if.issue_rd != '0) && !sb_if.flush_mask[0]) begin
        nw.rd  = sb_if.issue_rd;
        nw.fp  = sb_if.issue_rd_fp;
        nw.age = 0;
        nxt.push_back(nw);
      end
      infl = nxt;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("stall", sb_if.stall, exp_stall());
      chk("accept", sb_if.accept, exp_accept());
      chk("unit_clr", sb_if.unit_clr, sb_if.flush_mask);
      chk("busy_count", sb_if.busy_count, infl.size());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.advance         = 1'b1;
    sb_if.issue_valid     = 1'b0;
    sb_if.issue_to_unit   = 1'b0;
    sb_if.issue_reg_write = 1'b0;
    sb_if.issue_rd_fp     = 1'b0;
    sb_if.issue_rd        = '0;
    sb_if.issue_rs_used   = '0;
    sb_if.issue_rs_fp     = '0;
    sb_if.issue_rs1       = '0;
    sb_if.issue_rs2       = '0;
    sb_if.issue_rs3       = '0;
    sb_if.flush_mask      = '0;
  endtask

  task automatic put(input bit unit, input bit wr, input bit dfp, input int rd,
                     input logic [2:0] used, input logic [2:0] sfp,
                     input int rs1, input int rs2, input int rs3);
    idle();
    sb_if.issue_valid     = 1'b1;
    sb_if.issue_to_unit   = unit;
    sb_if.issue_reg_write = wr;
    sb_if.issue_rd_fp     = dfp;
    sb_if.issue_rd        = AW'(rd);
    sb_if.issue_rs_used   = used;
    sb_if.issue_rs_fp     = sfp;
    sb_if.issue_rs1       = AW'(rs1);
    sb_if.issue_rs2       = AW'(rs2);
    sb_if.issue_rs3       = AW'(rs3);
  endtask

  task automatic drain();
    idle();
    repeat (LAT + 1) cyc();
  endtask

  initial begin
    // Reset cycle with a plain issue request pending.
    idle();
    sb_if.issue_valid = 1'b1;
    #4;
    chk("rst_stall", sb_if.stall, 0);
    chk("rst_accept", sb_if.accept, 1);
    chk("rst_unit_clr", sb_if.unit_clr, 0);
    cyc(); #3;
    chk("rst_busy", sb_if.busy_count, 0);
    cyc();
    reset = 1'b0;
    drain();

    // FP RAW: f5 producer, then dependent rs1=f5 every cycle.
    put(1, 1, 1, 5, 3'b000, 3'b000, 0, 0, 0); #3;
    chk("f5_accept", sb_if.accept, 1);
    cyc();
    put(0, 0, 0, 0, 3'b001, 3'b001, 5, 0, 0); #3;
    chk("f5_busy", sb_if.busy_count, 1);
    n = 0;
    while (sb_if.stall && n < 10) begin
      n++;
      cyc(); #3;
    end
    chk("raw_f5_stall_cycles", n, RAW_STALLS);
    chk("raw_f5_dep_accept", sb_if.accept, 1);
    cyc();
    drain();

    // x0 is never tracked, x7 is; f7 is a different register.
    put(1, 1, 0, 0, 3'b000, 3'b000, 0, 0, 0); #3;
    chk("x0_accept", sb_if.accept, 1);
    cyc();
    put(1, 1, 0, 7, 3'b000, 3'b000, 0, 0, 0); #3;
    chk("x7_accept", sb_if.accept, 1);
    chk("x0_not_recorded", sb_if.busy_count, 0);
    cyc();
    put(0, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0); #3;
    chk("src_x0_no_stall", sb_if.stall, 0);
    chk("x7_busy", sb_if.busy_count, 1);
    cyc();
    put(0, 0, 0, 0, 3'b100, 3'b000, 0, 0, 7); #3;
    chk("src_x7_stall", sb_if.stall, 1);
    cyc();
    put(0, 0, 0, 0, 3'b010, 3'b010, 0, 7, 0); #3;
    chk("src_f7_no_stall", sb_if.stall, 0);
    cyc();
    drain();

    // WAW: unit op to x9, then ALU op writing x9.
    put(1, 1, 0, 9, 3'b000, 3'b000, 0, 0, 0); #3;
    chk("x9_accept", sb_if.accept, 1);
    cyc();
    put(0, 1, 0, 9, 3'b000, 3'b000, 0, 0, 0); #3;
    n = 0;
    while (sb_if.stall && n < 10) begin
      n++;
      cyc(); #3;
    end
    chk("waw_x9_stall_cycles", n, 2);
    chk("waw_x9_accept", sb_if.accept, 1);
    cyc();
    drain();

    // Flush of slots 0 and 1 while the pipe is held.
    put(1, 1, 1, 3, 3'b000, 3'b000, 0, 0, 0);
    cyc();
    put(1, 1, 1, 4, 3'b000, 3'b000, 0, 0, 0);
    cyc();
    idle();
    sb_if.advance    = 1'b0;
    sb_if.flush_mask = 3'b011; #3;
    chk("flush_unit_clr", sb_if.unit_clr, 3'b011);
    chk("flush_busy_before", sb_if.busy_count, 2);
    cyc();
    put(0, 0, 0, 0, 3'b001, 3'b001, 3, 0, 0); #3;
    chk("flush_busy_after", sb_if.busy_count, 0);
    chk("flush_dep_accept", sb_if.accept, 1);
    // Flush of slot 0 coincident with accept discards the new entry.
    cyc();
    put(1, 1, 1, 6, 3'b000, 3'b000, 0, 0, 0);
    sb_if.flush_mask = 3'b001; #3;
    chk("flush0_accept", sb_if.accept, 1);
    cyc();
    put(0, 0, 0, 0, 3'b001, 3'b001, 6, 0, 0); #3;
    chk("flush0_busy", sb_if.busy_count, 0);
    chk("flush0_dep_no_stall", sb_if.stall, 0);
    cyc();
    drain();

    // Back-to-back distinct destinations fill the shadow.
    for (int i = 0; i < 4; i++) begin
      put(1, 1, 1, 10 + i, 3'b000, 3'b000, 0, 0, 0); #3;
      chk("b2b_accept", sb_if.accept, 1);
      cyc();
    end
    idle(); #3;
    chk("b2b_busy_full", sb_if.busy_count, 3);
    cyc();
    drain();

    // Pipe held for four cycles with f8 in slot 1, then reset.
    put(1, 1, 1, 8, 3'b000, 3'b000, 0, 0, 0);
    cyc();
    idle();
    cyc();
    for (int i = 0; i < 4; i++) begin
      put(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
      sb_if.advance = 1'b0; #3;
      chk("hold_stall", sb_if.stall, 1);
      chk("hold_accept", sb_if.accept, 0);
      chk("hold_busy", sb_if.busy_count, 1);
      cyc();
    end
    put(0, 0, 0, 0, 3'b001, 3'b001, 8, 0, 0); #3;
    chk("hold_f8_still_slot1", sb_if.stall, 1);
    cyc();
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
    put(0, 0, 0, 0, 3'b001, 3'b001, 8, 0, 0); #3;
    chk("midrst_busy", sb_if.busy_count, 0);
    chk("midrst_f8_no_stall", sb_if.stall, 0);
    cyc();
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
